// File: rtl/koder_serijalizator_if.sv
// Encoder-to-serializer link: parallel code word handshake plus the serial line outputs.
// master = encoder side driving the word, slave = the serializer.
interface koder_serijalizator_if #(
    parameter int unsigned SIRINA = 41
);
    logic [SIRINA-1:0] ulaz_koder;
    logic              ulaz_valid;
    logic              ulaz_spreman;
    logic              serijski_izlaz;
    logic              okvir_aktivan;
    logic              greska_parnosti;
    logic              gotovo;

    modport master (
        output ulaz_koder,
        output ulaz_valid,
        input  ulaz_spreman,
        input  serijski_izlaz,
        input  okvir_aktivan,
        input  greska_parnosti,
        input  gotovo
    );

    modport slave (
        input  ulaz_koder,
        input  ulaz_valid,
        output ulaz_spreman,
        output serijski_izlaz,
        output okvir_aktivan,
        output greska_parnosti,
        output gotovo
    );
endinterface

// File: rtl/koder_serijalizator.sv
// Serializes a parity-protected code word as an idle-high, start/stop framed, MSB-first
// bit stream with CLK_PO_BITU clock cycles per bit; parity is re-checked on capture.
module koder_serijalizator #(
    parameter int unsigned SIRINA      = 41,
    parameter int unsigned CLK_PO_BITU = 4
) (
    input  logic                clk,
    input  logic                rst,
    koder_serijalizator_if.slave bus
);

    localparam int unsigned PerW = (CLK_PO_BITU > 1) ? $clog2(CLK_PO_BITU) : 1;
    localparam int unsigned BitW = $clog2(SIRINA);
    localparam logic [PerW-1:0] PerMax = PerW'(CLK_PO_BITU - 1);
    localparam logic [BitW-1:0] BitMax = BitW'(SIRINA - 1);

    typedef enum logic [1:0] {
        StMirovanje = 2'd0,
        StStart     = 2'd1,
        StPodaci    = 2'd2,
        StStop      = 2'd3
    } stanje_e;

    stanje_e           r_stanje;
    logic [SIRINA-1:0] r_shift;
    logic [PerW-1:0]   r_per;
    logic [BitW-1:0]   r_bit;
    logic              r_linija;
    logic              r_spreman;
    logic              r_okvir;
    logic              r_greska;
    logic              r_gotovo;

    wire w_per_kraj = (r_per == PerMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stanje  <= StMirovanje;
            r_shift   <= '0;
            r_per     <= '0;
            r_bit     <= '0;
            r_linija  <= 1'b1;
            r_spreman <= 1'b1;
            r_okvir   <= 1'b0;
            r_greska  <= 1'b0;
            r_gotovo  <= 1'b0;
        end else begin
            r_gotovo <= 1'b0;
            unique case (r_stanje)
                StMirovanje: begin
                    if (bus.ulaz_valid && r_spreman) begin
                        r_shift   <= bus.ulaz_koder;
                        r_greska  <= ^bus.ulaz_koder;
                        r_stanje  <= StStart;
                        r_spreman <= 1'b0;
                        r_okvir   <= 1'b1;
                        r_linija  <= 1'b0;
                        r_per     <= '0;
                        r_bit     <= '0;
                    end
                end
                StStart: begin
                    if (w_per_kraj) begin
                        r_stanje <= StPodaci;
                        r_per    <= '0;
                        r_bit    <= '0;
                        r_linija <= r_shift[SIRINA-1];
                        r_shift  <= {r_shift[SIRINA-2:0], 1'b0};
                    end else begin
                        r_per <= r_per + 1'b1;
                    end
                end
                StPodaci: begin
                    if (w_per_kraj) begin
                        r_per <= '0;
                        if (r_bit == BitMax) begin
                            r_stanje <= StStop;
                            r_bit    <= '0;
                            r_linija <= 1'b1;
                        end else begin
                            // Next bit is already at the MSB of the shift register.
                            r_bit    <= r_bit + 1'b1;
                            r_linija <= r_shift[SIRINA-1];
                            r_shift  <= {r_shift[SIRINA-2:0], 1'b0};
                        end
                    end else begin
                        r_per <= r_per + 1'b1;
                    end
                end
                StStop: begin
                    if (w_per_kraj) begin
                        r_stanje  <= StMirovanje;
                        r_per     <= '0;
                        r_gotovo  <= 1'b1;
                        r_spreman <= 1'b1;
                        r_okvir   <= 1'b0;
                    end else begin
                        r_per <= r_per + 1'b1;
                    end
                end
                default: begin
                    r_stanje  <= StMirovanje;
                    r_per     <= '0;
                    r_bit     <= '0;
                    r_linija  <= 1'b1;
                    r_spreman <= 1'b1;
                    r_okvir   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ulaz_spreman    = r_spreman;
    assign bus.serijski_izlaz  = r_linija;
    assign bus.okvir_aktivan   = r_okvir;
    assign bus.greska_parnosti = r_greska;
    assign bus.gotovo          = r_gotovo;

endmodule

// File: tb/tb_koder_serijalizator.sv
// Bench for koder_serijalizator: a 41-bit/4-cycle instance and a 13-bit/1-cycle instance,
// driven by vector tables plus hand-written back-to-back and mid-frame reset sequences.
module tb_koder_serijalizator;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_chk;
    int   n_fail;

    koder_serijalizator_if #(.SIRINA(41)) bus_a ();
    koder_serijalizator_if #(.SIRINA(13)) bus_b ();

    koder_serijalizator #(.SIRINA(41), .CLK_PO_BITU(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    koder_serijalizator #(.SIRINA(13), .CLK_PO_BITU(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [40:0] word;
        logic        par;
    } vec41_t;

    typedef struct {
        logic [12:0] word;
        logic [14:0] seq;
        logic        par;
    } vec13_t;

    vec41_t tab41[5];
    vec13_t tab13[4];

    // Observed bundle order: {line, okvir, spreman, gotovo, greska}
    function automatic logic [4:0] obs_a();
        return {bus_a.serijski_izlaz, bus_a.okvir_aktivan, bus_a.ulaz_spreman,
                bus_a.gotovo, bus_a.greska_parnosti};
    endfunction

    function automatic logic [4:0] obs_b();
        return {bus_b.serijski_izlaz, bus_b.okvir_aktivan, bus_b.ulaz_spreman,
                bus_b.gotovo, bus_b.greska_parnosti};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (line,okvir,spreman,gotovo,greska)",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame bit j/4: 0 = start, 1..41 = word MSB first, 42 = stop
    function automatic logic frame_bit41(input logic [40:0] w, input int j);
        int idx;
        idx = j / 4;
        if (idx == 0) return 1'b0;
        if (idx <= 41) return w[41 - idx];
        return 1'b1;
    endfunction

    task automatic send41(input logic [40:0] w);
        bus_a.ulaz_koder = w;
        bus_a.ulaz_valid = 1'b1;
        step();
        bus_a.ulaz_valid = 1'b0;
    endtask

    task automatic send13(input logic [12:0] w);
        bus_b.ulaz_koder = w;
        bus_b.ulaz_valid = 1'b1;
        step();
        bus_b.ulaz_valid = 1'b0;
    endtask

    // Called right after the accept edge; returns right after the gotovo edge.
    task automatic check_frame41(input string tag, input logic [40:0] w, input logic par);
        for (int j = 0; j < 172; j++) begin
            chk($sformatf("%s cyc%0d", tag, j), obs_a(), {frame_bit41(w, j), 1'b1, 1'b0, 1'b0, par});
            step();
        end
        chk($sformatf("%s end", tag), obs_a(), {1'b1, 1'b0, 1'b1, 1'b1, par});
    endtask

    task automatic check_frame13(input string tag, input logic [14:0] seq, input logic par);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("%s cyc%0d", tag, j), obs_b(), {seq[14-j], 1'b1, 1'b0, 1'b0, par});
            step();
        end
        chk($sformatf("%s end", tag), obs_b(), {1'b1, 1'b0, 1'b1, 1'b1, par});
    endtask

    initial begin
        int pulses;
        n_chk  = 0;
        n_fail = 0;

        tab41[0] = '{word: 41'h0C8D4DED8CB, par: 1'b0};
        tab41[1] = '{word: 41'h0C8D4DED8CA, par: 1'b1};
        tab41[2] = '{word: 41'h00000000000, par: 1'b0};
        tab41[3] = '{word: 41'h1FFFFFFFFFF, par: 1'b1};
        tab41[4] = '{word: 41'h10000000001, par: 1'b0};

        tab13[0] = '{word: 13'h0C90, seq: 15'b001100100100001, par: 1'b0};
        tab13[1] = '{word: 13'h1FFF, seq: 15'b011111111111111, par: 1'b1};
        tab13[2] = '{word: 13'h0001, seq: 15'b000000000000011, par: 1'b1};
        tab13[3] = '{word: 13'h1001, seq: 15'b010000000000011, par: 1'b0};

        bus_a.ulaz_koder = '0;
        bus_a.ulaz_valid = 1'b0;
        bus_b.ulaz_koder = '0;
        bus_b.ulaz_valid = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset and idle
        repeat (3) step();
        chk("reset a", obs_a(), 5'b10100);
        chk("reset b", obs_b(), 5'b10100);
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle a %0d", i), obs_a(), 5'b10100);
            chk($sformatf("idle b %0d", i), obs_b(), 5'b10100);
        end

        // Table-driven frames on both instances
        for (int v = 0; v < 5; v++) begin
            send41(tab41[v].word);
            check_frame41($sformatf("w41 v%0d", v), tab41[v].word, tab41[v].par);
            step();
            chk($sformatf("w41 v%0d post", v), obs_a(), {1'b1, 1'b0, 1'b1, 1'b0, tab41[v].par});
        end
        for (int v = 0; v < 4; v++) begin
            send13(tab13[v].word);
            check_frame13($sformatf("w13 v%0d", v), tab13[v].seq, tab13[v].par);
            step();
            chk($sformatf("w13 v%0d post", v), obs_b(), {1'b1, 1'b0, 1'b1, 1'b0, tab13[v].par});
        end

        // Backpressure: second word held valid for the whole first frame
        send41(41'h0C8D4DED8CB);
        bus_a.ulaz_koder = 41'h0C8D4DED8CA;
        bus_a.ulaz_valid = 1'b1;
        check_frame41("b2b first", 41'h0C8D4DED8CB, 1'b0);
        step();
        bus_a.ulaz_valid = 1'b0;
        check_frame41("b2b second", 41'h0C8D4DED8CA, 1'b1);
        step();

        // Mid-frame reset during data bit 10 (bit 10 occupies edges k+44..k+47)
        send41(41'h0C8D4DED8CB);
        repeat (45) step();
        chk("pre-reset frame", obs_a(),
            {frame_bit41(41'h0C8D4DED8CB, 45), 1'b1, 1'b0, 1'b0, 1'b0});
        rst_a = 1'b1;
        step();
        chk("mid reset", obs_a(), 5'b10100);
        rst_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus_a.gotovo === 1'b1 || bus_a.okvir_aktivan !== 1'b0) pulses++;
        end
        n_chk++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL no gotovo after reset: got %0d active cycles expected 0", pulses);
        end
        send41(41'h1FFFFFFFFFF);
        check_frame41("after reset", 41'h1FFFFFFFFFF, 1'b1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
